// File: rtl/core_pkg.sv
// ============================================================================
// Module   : core_pkg
// Purpose  : Shared core widths, operand types and the operand-slot state enum.
// Revision : 1.0
// ============================================================================
`default_nettype none

package core_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_FRESH = 2'd1,
        SLOT_HELD  = 2'd2
    } slot_state_e;

    // x0 is hardwired to zero, so a write to it never forwards.
    function automatic logic wb_hits(input logic en, input reg_addr_t wa, input reg_addr_t ra);
        return en && (wa == ra) && (ra != '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/core_id_operand_slot.sv
// ============================================================================
// Module   : core_id_operand_slot
// Purpose  : One operand lane: slot FSM, issue-edge bypass, stall hold, x0 forcing.
//            Macro CORE_ID_OPERAND_FETCH_SNOOP_EN enables write-back snooping
//            of a presented operand.
// Revision : 1.0
// ============================================================================
`default_nettype none

module core_id_operand_slot
    import core_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      issue,
    input  logic      accept,
    input  reg_addr_t rs,
    input  xlen_t     rf_data,
    input  logic      wb_en,
    input  reg_addr_t wb_addr,
    input  xlen_t     wb_data,
    output xlen_t     data
);

    slot_state_e state_q, state_d;
    reg_addr_t   addr_q, addr_d;
    logic        byp_vld_q, byp_vld_d;
    xlen_t       byp_q, byp_d;
    xlen_t       hold_q, hold_d;
    xlen_t       w_fresh;
    logic        w_snoop_hit;

    assign w_fresh = (addr_q == '0) ? '0 : (byp_vld_q ? byp_q : rf_data);

`ifdef CORE_ID_OPERAND_FETCH_SNOOP_EN
    assign w_snoop_hit = wb_hits(wb_en, wb_addr, addr_q);
`else
    assign w_snoop_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        byp_vld_d = byp_vld_q;
        byp_d     = byp_q;
        hold_d    = hold_q;
        case (state_q)
            SLOT_EMPTY: if (issue) state_d = SLOT_FRESH;
            SLOT_FRESH: begin
                if (accept) begin
                    state_d = issue ? SLOT_FRESH : SLOT_EMPTY;
                end else begin
                    // Stalled: freeze the resolved operand before the RF read port moves on.
                    state_d = SLOT_HELD;
                    hold_d  = w_snoop_hit ? wb_data : w_fresh;
                end
            end
            SLOT_HELD: begin
                if (accept) begin
                    state_d = issue ? SLOT_FRESH : SLOT_EMPTY;
                end else if (w_snoop_hit) begin
                    hold_d = wb_data;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
        if (issue) begin
            addr_d    = rs;
            byp_vld_d = wb_hits(wb_en, wb_addr, rs);
            byp_d     = wb_hits(wb_en, wb_addr, rs) ? wb_data : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SLOT_EMPTY;
            addr_q    <= '0;
            byp_vld_q <= 1'b0;
            byp_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            byp_vld_q <= byp_vld_d;
            byp_q     <= byp_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin
        case (state_q)
            SLOT_FRESH: data = w_fresh;
            SLOT_HELD:  data = hold_q;
            default:    data = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/core_id_operand_fetch.sv
// ============================================================================
// Module   : core_id_operand_fetch
// Purpose  : Single-entry decode operand-fetch stage with write-back bypass.
//            Macro CORE_ID_OPERAND_FETCH_SNOOP_EN enables operand snooping.
// Revision : 1.0
// ============================================================================
`default_nettype none

module core_id_operand_fetch
    import core_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      in_valid,
    output logic      in_ready,
    input  reg_addr_t in_rs1,
    input  reg_addr_t in_rs2,
    input  xlen_t     in_info,
    output reg_addr_t rf_read_0_addr,
    output reg_addr_t rf_read_1_addr,
    input  xlen_t     rf_read_0_data,
    input  xlen_t     rf_read_1_data,
    input  logic      wb_en,
    input  reg_addr_t wb_addr,
    input  xlen_t     wb_data,
    output logic      out_valid,
    input  logic      out_ready,
    output xlen_t     out_rs1_data,
    output xlen_t     out_rs2_data,
    output xlen_t     out_info
);

    logic  out_valid_q, out_valid_d;
    xlen_t out_info_q, out_info_d;
    logic  w_issue, w_accept;

    assign in_ready       = !out_valid_q || out_ready;
    assign w_issue        = in_valid && in_ready;
    assign w_accept       = out_valid_q && out_ready;
    assign rf_read_0_addr = in_rs1;
    assign rf_read_1_addr = in_rs2;
    assign out_valid      = out_valid_q;
    assign out_info       = out_info_q;

    always_comb begin
        out_valid_d = out_valid_q;
        out_info_d  = out_info_q;
        if (w_issue) begin
            out_valid_d = 1'b1;
            out_info_d  = in_info;
        end else if (w_accept) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_info_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_info_q  <= out_info_d;
        end
    end

    core_id_operand_slot u_slot_rs1 (
        .clk     (clk),
        .rst     (rst),
        .issue   (w_issue),
        .accept  (w_accept),
        .rs      (in_rs1),
        .rf_data (rf_read_0_data),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .data    (out_rs1_data)
    );

    core_id_operand_slot u_slot_rs2 (
        .clk     (clk),
        .rst     (rst),
        .issue   (w_issue),
        .accept  (w_accept),
        .rs      (in_rs2),
        .rf_data (rf_read_1_data),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .data    (out_rs2_data)
    );

endmodule

`default_nettype wire

// File: doc/core_id_operand_fetch.md
CORE_ID_OPERAND_FETCH -- requirements
Module: core_id_operand_fetch

Interface
REQ-001 clk  in  1  sole clock; all state updates on posedge clk.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 in_valid  in  1  decode presents an operand request.
REQ-004 in_ready  out  1  request accepted when in_valid && in_ready at posedge clk ("issue").
REQ-005 in_rs1, in_rs2  in  5 each  source register addresses.
REQ-006 in_info  in  32  opaque tag (e.g. PC), passed through unchanged.
REQ-007 rf_read_0_addr, rf_read_1_addr  out  5 each  register file read addresses.
REQ-008 rf_read_0_data, rf_read_1_data  in  32 each  register file data, valid one cycle after the address (synchronous read).
REQ-009 wb_en, wb_addr, wb_data  in  1/5/32  snoop of the register file write port.
REQ-010 out_valid  out  1  operands valid.
REQ-011 out_ready  in  1  consumer accepts when out_valid && out_ready at posedge.
REQ-012 out_rs1_data, out_rs2_data  out  32 each  resolved operands.
REQ-013 out_info  out  32  tag of the presented request.

Function
REQ-014 Single-entry stage; in_ready = !out_valid || out_ready (combinational), giving one issue per cycle at full throughput.
REQ-015 rf_read_N_addr SHALL equal in_rsN combinationally, so data for an issue at edge E0 arrives on rf_read_N_data in the cycle after E0.
REQ-016 Latency: issue at E0 -> out_valid=1 in the cycle after E0.
REQ-017 Per-operand FSM: EMPTY, FRESH (output sourced from rf_read data or bypass register), HELD (output sourced from hold register).
REQ-018 EMPTY->FRESH on issue; FRESH->EMPTY on accept without issue; FRESH->FRESH on accept with issue; FRESH->HELD on !out_ready (capture resolved operand into hold register at that edge); HELD->FRESH on accept with issue; HELD->EMPTY on accept without issue.
REQ-019 Issue-edge bypass: if wb_en && wb_addr==in_rsN && in_rsN!=0 at E0, the operand SHALL be wb_data as sampled at E0, not rf_read_N_data.
REQ-020 in_rsN==0 SHALL yield operand 0 regardless of register file data or wb traffic; wb_addr==0 never matches.
REQ-021 Output data and out_info SHALL stay stable while out_valid && !out_ready (except REQ-026 updates).
REQ-022 Both operands share one out_valid; no per-operand handshake.
REQ-023 wb to a different address, or wb_en=0, SHALL have no effect.

Reset
REQ-024 While rst=1: FSM=EMPTY, out_valid=0, out_rs1_data=out_rs2_data=0, out_info=0, bypass/hold registers=0; in_ready=1 on the first cycle after rst deasserts.
REQ-025 rst asserted mid-operation SHALL discard the pending entry, with no accept reported.

Configuration
REQ-026 Macro CORE_ID_OPERAND_FETCH_SNOOP_EN: when defined, in FRESH or HELD a matching wb (REQ-019 rules, against the held address) SHALL overwrite that operand from the next cycle; when undefined, presented operands are frozen after issue.

Structure
REQ-027 Shared package core_pkg holds XLEN=32, REG_ADDR_W=5, typedef reg_addr_t, typedef xlen_t, and the slot-state enum.
REQ-028 One sub-module core_id_operand_slot (FSM, bypass, hold, zero-forcing for one operand), instantiated twice.

Verification
REQ-029 Preload x5=0x11111111; issue rs1=5, rs2=0, out_ready=1 -> next cycle out_valid=1, out_rs1_data=0x11111111, out_rs2_data=0.
REQ-030 Issue rs1=7 while wb_en=1, wb_addr=7, wb_data=0xDEADBEEF at the same edge -> out_rs1_data=0xDEADBEEF (not the old x7).
REQ-031 out_ready=0 for 3 cycles after issue while the RF read address changes -> out data and out_info stable; in_ready=0; accept on the 4th cycle.
REQ-032 Held rs2=9, wb x9=0x5A5A5A5A during stall -> out_rs2_data becomes 0x5A5A5A5A with SNOOP_EN, stays at the old value without it.
REQ-033 Back-to-back issues over 8 cycles with out_ready=1 -> 8 accepts, in order, in_ready constantly 1.
REQ-034 Assert rst with out_valid=1 -> next cycle out_valid=0, all outputs 0; wb_addr=0 with rs1=0 -> operand 0.
